dmem_arbiter: RTL

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arb_pkg.sv | 17 +
 rtl/dmem_arb_starve.sv | 41 ++++
 rtl/dmem_arbiter.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
// Holds the arbitration FSM state and the port index encoding.
package dmem_arb_pkg;

    typedef enum logic {
        NORMAL = 1'b0,
        FAIR   = 1'b1
    } arb_state_e;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_DBG = 1'b1;

    localparam logic [31:0] DEFAULT_DATA_START_ADDRESS = 32'h0080_0000;

    localparam int unsigned STARVE_CNT_W = 4;

endpackage

// File: rtl/dmem_arb_starve.sv
// Starvation counter for the debug/loader port: counts consecutive denied cycles
// and flags when the next count reaches the forced-win threshold.
module dmem_arb_starve
    import dmem_arb_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    p1_req,
    input  logic                    p1_gnt,
    output logic                    starve_hit,
    output logic [STARVE_CNT_W-1:0] starve_cnt
);

    localparam logic [STARVE_CNT_W-1:0] LIMIT   = STARVE_CNT_W'(STARVE_LIMIT);
    localparam logic [STARVE_CNT_W-1:0] CNT_MAX = '1;

    logic [STARVE_CNT_W-1:0] cnt_next;

    // Saturate so a port held off by a huge limit never wraps back to zero.
    always_comb begin
        cnt_next = '0;
        if (p1_req && !p1_gnt) begin
            cnt_next = (starve_cnt == CNT_MAX) ? CNT_MAX : starve_cnt + 1'b1;
        end
    end

    // Evaluated on the next value so the FSM is already FAIR in the cycle the
    // registered count lands on the limit.
    assign starve_hit = (cnt_next >= LIMIT);

    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= '0;
        end else begin
            starve_cnt <= cnt_next;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of a synchronous single-port data memory, with
// starvation protection for port 1 and data-segment range checking.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT       = 4,
    parameter logic [31:0] DATA_START_ADDRESS = DEFAULT_DATA_START_ADDRESS,
    parameter int unsigned DATA_ADDR_BITS     = 13
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    p0_req,
    input  logic                    p0_we,
    input  logic [31:0]             p0_addr,
    input  logic [31:0]             p0_wdata,
    output logic                    p0_gnt,
    output logic                    p0_rvalid,
    output logic [31:0]             p0_rdata,
    output logic                    p0_err,
    input  logic                    p1_req,
    input  logic                    p1_we,
    input  logic [31:0]             p1_addr,
    input  logic [31:0]             p1_wdata,
    output logic                    p1_gnt,
    output logic                    p1_rvalid,
    output logic [31:0]             p1_rdata,
    output logic                    p1_err,
    output logic [31:0]             mem_addr,
    output logic                    mem_we,
    output logic [31:0]             mem_wdata,
    input  logic [31:0]             mem_rdata,
    output arb_state_e              dbg_state,
    output logic [STARVE_CNT_W-1:0] dbg_starve_cnt
);

    // Handshake: a port's request is accepted in the cycle where req and gnt are
    // both 1; req and payload stay stable until then. Reads answer with rvalid
    // exactly one cycle later; out-of-range accesses answer with err one cycle later.

    arb_state_e state;
    logic       starve_hit;

    logic        p0_in_seg;
    logic        p1_in_seg;
    logic        any_gnt;
    logic        sel_we;
    logic        sel_in_seg;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;

    logic        pipe_vld;
    logic        pipe_port;
    logic        pipe_rd;
    logic        pipe_oor;
    logic        own0;
    logic        own1;

    assign p0_in_seg = ((p0_addr >> DATA_ADDR_BITS) == (DATA_START_ADDRESS >> DATA_ADDR_BITS));
    assign p1_in_seg = ((p1_addr >> DATA_ADDR_BITS) == (DATA_START_ADDRESS >> DATA_ADDR_BITS));

    always_comb begin
        p0_gnt = 1'b0;
        p1_gnt = 1'b0;
        if (!rst) begin
            if (state == FAIR) begin
                if (p1_req) begin
                    p1_gnt = 1'b1;
                end else if (p0_req) begin
                    p0_gnt = 1'b1;
                end
            end else begin
                if (p0_req) begin
                    p0_gnt = 1'b1;
                end else if (p1_req) begin
                    p1_gnt = 1'b1;
                end
            end
        end
    end

    assign any_gnt    = p0_gnt | p1_gnt;
    assign sel_we     = p1_gnt ? p1_we     : p0_we;
    assign sel_in_seg = p1_gnt ? p1_in_seg : p0_in_seg;
    assign sel_addr   = p1_gnt ? p1_addr   : p0_addr;
    assign sel_wdata  = p1_gnt ? p1_wdata  : p0_wdata;

    assign mem_addr  = any_gnt ? sel_addr  : 32'h0;
    assign mem_wdata = any_gnt ? sel_wdata : 32'h0;
    // Out-of-range writes are accepted but must never touch memory.
    assign mem_we    = any_gnt & sel_we & sel_in_seg;

    dmem_arb_starve #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_starve (
        .clk        (clk),
        .rst        (rst),
        .p1_req     (p1_req),
        .p1_gnt     (p1_gnt),
        .starve_hit (starve_hit),
        .starve_cnt (dbg_starve_cnt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= NORMAL;
        end else begin
            case (state)
                NORMAL:  if (starve_hit) state <= FAIR;
                FAIR:    if (p1_gnt)     state <= NORMAL;
                default: state <= NORMAL;
            endcase
        end
    end

    assign dbg_state = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            pipe_vld  <= 1'b0;
            pipe_port <= PORT_CPU;
            pipe_rd   <= 1'b0;
            pipe_oor  <= 1'b0;
        end else begin
            pipe_vld  <= any_gnt;
            pipe_port <= p1_gnt ? PORT_DBG : PORT_CPU;
            pipe_rd   <= ~sel_we;
            pipe_oor  <= ~sel_in_seg;
        end
    end

    // Gating with rst drops a response still in flight when reset arrives.
    assign own0 = !rst && pipe_vld && (pipe_port == PORT_CPU);
    assign own1 = !rst && pipe_vld && (pipe_port == PORT_DBG);

    assign p0_rvalid = own0 & pipe_rd;
    assign p0_err    = own0 & pipe_oor;
    assign p0_rdata  = (p0_rvalid && !pipe_oor) ? mem_rdata : 32'h0;

    assign p1_rvalid = own1 & pipe_rd;
    assign p1_err    = own1 & pipe_oor;
    assign p1_rdata  = (p1_rvalid && !pipe_oor) ? mem_rdata : 32'h0;

endmodule
